scan_chain_ctrl: RTL and testbench

//  Tester-side driver for a serial scan chain built from scan flops (D, SD, SE, CK, Q).

---
 rtl/scan_chain_ctrl_if.sv | 25 ++
 rtl/scan_chain_ctrl.sv | 79 +++++++
 tb/tb_scan_chain_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/scan_chain_ctrl_if.sv
// Scan-run request/response bundle between tester sequencer and scan driver.
// Carries the run request, serial chain pins and the unload result.
interface scan_chain_ctrl_if #(
   parameter int CHAIN_LEN = 16
);
   logic                 START;
   logic                 CAPTURE_EN;
   logic [CHAIN_LEN-1:0] LOAD_DATA;
   logic                 SCAN_IN;
   logic                 SE;
   logic                 SD;
   logic                 BUSY;
   logic                 DONE;
   logic [CHAIN_LEN-1:0] UNLOAD_DATA;

   modport master (
      output START, CAPTURE_EN, LOAD_DATA, SCAN_IN,
      input  SE, SD, BUSY, DONE, UNLOAD_DATA
   );

   modport slave (
      input  START, CAPTURE_EN, LOAD_DATA, SCAN_IN,
      output SE, SD, BUSY, DONE, UNLOAD_DATA
   );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Serial scan chain driver: shifts a vector in while unloading the old one,
// then optionally pulses one functional capture cycle before DONE.
module scan_chain_ctrl #(
   parameter  int CHAIN_LEN = 16,
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input logic               CK,
   input logic               RST,
   scan_chain_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_CAPT,
      S_FIN
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

   state_t               r_state;
   state_t               w_next;
   logic [CHAIN_LEN-1:0] r_sh;
   logic [CHAIN_LEN-1:0] r_unload;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_cap;
   logic                 w_accept;
   logic                 w_se;

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.START) begin
               w_accept = 1'b1;
               w_next   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_cnt == LAST)
               w_next = r_cap ? S_CAPT : S_FIN;
         end
         S_CAPT:  w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         r_state  <= S_IDLE;
         r_sh     <= '0;
         r_unload <= '0;
         r_cnt    <= '0;
         r_cap    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_sh  <= bus.LOAD_DATA;
            r_cap <= bus.CAPTURE_EN;
            r_cnt <= '0;
         end else if (r_state == S_SHIFT) begin
            // tail is sampled on the same edge the chain advances
            r_sh     <= {r_sh[CHAIN_LEN-2:0], 1'b0};
            r_unload <= {r_unload[CHAIN_LEN-2:0], bus.SCAN_IN};
            r_cnt    <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign w_se            = (r_state == S_SHIFT);
   assign bus.SE          = w_se;
   assign bus.SD          = w_se & r_sh[CHAIN_LEN-1];
   assign bus.BUSY        = (r_state != S_IDLE);
   assign bus.DONE        = (r_state == S_FIN);
   assign bus.UNLOAD_DATA = r_unload;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: behavioural scan chains on 4- and 2-flop
// drivers, directed scenarios followed by randomized runs.
module tb_scan_chain_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   scan_chain_ctrl_if #(.CHAIN_LEN(4)) bus4 ();
   scan_chain_ctrl_if #(.CHAIN_LEN(2)) bus2 ();

   scan_chain_ctrl #(.CHAIN_LEN(4)) dut4 (
      .CK  (clk),
      .RST (rst),
      .bus (bus4.slave)
   );

   scan_chain_ctrl #(.CHAIN_LEN(2)) dut2 (
      .CK  (clk),
      .RST (rst),
      .bus (bus2.slave)
   );

   // chain clock is gated by the tester to the shift and capture cycles
   logic [3:0] chain4 = '0;
   logic [1:0] chain2 = '0;
   bit         dinv   = 1'b0;

   assign bus4.SCAN_IN = chain4[3];
   assign bus2.SCAN_IN = chain2[1];

   always @(posedge clk) begin
      if (bus4.BUSY && !bus4.DONE)
         chain4 <= bus4.SE ? {chain4[2:0], bus4.SD}
                           : (dinv ? ~chain4 : chain4);
      if (bus2.BUSY && !bus2.DONE)
         chain2 <= bus2.SE ? {chain2[0], bus2.SD} : chain2;
   end

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [3:0] exp_chain4 = '0;

   task automatic run4(input logic [3:0] ld, input bit cap,
                       input bit noise, input bit chk_unl);
      logic [3:0] exp_unl;
      exp_unl = exp_chain4;
      bus4.START      = 1'b1;
      bus4.LOAD_DATA  = ld;
      bus4.CAPTURE_EN = cap;
      @(negedge clk);
      bus4.LOAD_DATA  = 4'($urandom);
      bus4.CAPTURE_EN = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
         bus4.START = noise && (k == 1);
         chk("shift_se",   16'(bus4.SE),   16'd1);
         chk("shift_sd",   16'(bus4.SD),   16'(ld[3-k]));
         chk("shift_busy", 16'(bus4.BUSY), 16'd1);
         chk("shift_done", 16'(bus4.DONE), 16'd0);
         @(negedge clk);
      end
      bus4.START = 1'b0;
      if (cap) begin
         chk("capt_se",   16'(bus4.SE),   16'd0);
         chk("capt_sd",   16'(bus4.SD),   16'd0);
         chk("capt_busy", 16'(bus4.BUSY), 16'd1);
         chk("capt_done", 16'(bus4.DONE), 16'd0);
         @(negedge clk);
      end
      bus4.START = noise;
      chk("fin_done", 16'(bus4.DONE), 16'd1);
      chk("fin_busy", 16'(bus4.BUSY), 16'd1);
      chk("fin_se",   16'(bus4.SE),   16'd0);
      if (chk_unl)
         chk("unload", 16'(bus4.UNLOAD_DATA), 16'(exp_unl));
      @(negedge clk);
      bus4.START = 1'b0;
      chk("idle_busy", 16'(bus4.BUSY), 16'd0);
      chk("idle_done", 16'(bus4.DONE), 16'd0);
      if (chk_unl)
         chk("unload_hold", 16'(bus4.UNLOAD_DATA), 16'(exp_unl));
      exp_chain4 = (cap && dinv) ? ~ld : ld;
      chk("chain", 16'(chain4), 16'(exp_chain4));
   endtask

   initial begin
      logic [3:0] rld;
      bit         rcap;
      rst             = 1'b1;
      bus4.START      = 1'b0;
      bus4.CAPTURE_EN = 1'b0;
      bus4.LOAD_DATA  = '0;
      bus2.START      = 1'b0;
      bus2.CAPTURE_EN = 1'b0;
      bus2.LOAD_DATA  = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_se",     16'(bus4.SE),          16'd0);
      chk("rst_sd",     16'(bus4.SD),          16'd0);
      chk("rst_busy",   16'(bus4.BUSY),        16'd0);
      chk("rst_done",   16'(bus4.DONE),        16'd0);
      chk("rst_unload", 16'(bus4.UNLOAD_DATA), 16'd0);
      rst = 1'b0;
      @(negedge clk);

      run4(4'b1011, 1'b0, 1'b0, 1'b1);
      run4(4'b0110, 1'b0, 1'b0, 1'b1);
      dinv = 1'b1;
      run4(4'b0110, 1'b1, 1'b0, 1'b1);
      run4(4'b0011, 1'b0, 1'b1, 1'b1);

      // abandon a run on its second shift cycle
      bus4.START     = 1'b1;
      bus4.LOAD_DATA = 4'b1100;
      @(negedge clk);
      bus4.START = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_se",     16'(bus4.SE),          16'd0);
      chk("mrst_sd",     16'(bus4.SD),          16'd0);
      chk("mrst_busy",   16'(bus4.BUSY),        16'd0);
      chk("mrst_done",   16'(bus4.DONE),        16'd0);
      chk("mrst_unload", 16'(bus4.UNLOAD_DATA), 16'd0);
      run4(4'b0101, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         rld  = 4'($urandom);
         rcap = 1'($urandom);
         dinv = 1'($urandom);
         run4(rld, rcap, 1'($urandom), 1'b1);
      end

      bus2.START     = 1'b1;
      bus2.LOAD_DATA = 2'b10;
      @(negedge clk);
      bus2.START     = 1'b0;
      bus2.LOAD_DATA = 2'b01;
      chk("n2_se0", 16'(bus2.SE), 16'd1);
      chk("n2_sd0", 16'(bus2.SD), 16'd1);
      @(negedge clk);
      chk("n2_se1", 16'(bus2.SE), 16'd1);
      chk("n2_sd1", 16'(bus2.SD), 16'd0);
      @(negedge clk);
      chk("n2_done",   16'(bus2.DONE),        16'd1);
      chk("n2_se2",    16'(bus2.SE),          16'd0);
      chk("n2_unload", 16'(bus2.UNLOAD_DATA), 16'd0);
      @(negedge clk);
      chk("n2_idle",  16'(bus2.BUSY), 16'd0);
      chk("n2_chain", 16'(chain2),    16'd2);

      bus2.START     = 1'b1;
      bus2.LOAD_DATA = 2'b01;
      @(negedge clk);
      bus2.START = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("n2_done_b",   16'(bus2.DONE),        16'd1);
      chk("n2_unload_b", 16'(bus2.UNLOAD_DATA), 16'd2);
      @(negedge clk);
      chk("n2_chain_b", 16'(chain2), 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
